// File: rtl/display_sr_pkg.sv
// Shared definitions for the digit-segment serial link (receiver, controller, benches).
package display_sr_pkg;

    localparam int NUM_DIGITS_DEF     = 6;
    localparam int BITS_PER_DIGIT_DEF = 8;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_RECV     = 2'd1,
        RX_OVERFLOW = 2'd2
    } rx_state_t;

endpackage

// File: rtl/display_sr_receiver_sync.sv
// Input synchronizer with registered rising-edge detector.
// q is delayed one extra flop so that it lines up with rise; a data line
// synchronized through this block is therefore sampled at the same point
// in time as the clock line's edge.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;

    // Synchronizer chain, edge history (always running) and registered edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
        end
    end

    assign q    = prev_r;
    assign rise = rise_r;

endmodule

// File: rtl/display_sr_receiver.sv
// Display-side receiver: rebuilds NUM_DIGITS segment bytes from the
// shift-clock / data / latch link and commits them on a well-formed latch.
module display_sr_receiver
    import display_sr_pkg::*;
#(
    parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
    parameter int BITS_PER_DIGIT = BITS_PER_DIGIT_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 sr_clk_in,
    input  logic                                 sr_data_in,
    input  logic                                 sr_latch_in,
    output logic [NUM_DIGITS*BITS_PER_DIGIT-1:0] digits_out,
    output logic                                 frame_valid,
    output logic                                 frame_err,
    output logic                                 overflow
);

    localparam int BCW = $clog2(BITS_PER_DIGIT);
    localparam int YCW = $clog2(NUM_DIGITS + 1);
    localparam int FW  = NUM_DIGITS * BITS_PER_DIGIT;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BITS_PER_DIGIT - 1);
    localparam logic [BCW-1:0] BIT_ONE   = {{(BCW-1){1'b0}}, 1'b1};
    localparam logic [YCW-1:0] BYTE_FULL = YCW'(NUM_DIGITS);
    localparam logic [YCW-1:0] BYTE_ONE  = {{(YCW-1){1'b0}}, 1'b1};

    logic clk_rise_s;
    logic latch_rise_s;
    logic data_s;
    logic clk_lvl_s;
    logic latch_lvl_s;
    logic data_rise_s;

    rx_state_t                state_r,    state_s;
    logic [BCW-1:0]           bit_cnt_r,  bit_cnt_s;
    logic [YCW-1:0]           byte_cnt_r, byte_cnt_s;
    logic [BITS_PER_DIGIT-1:0] shreg_r,   shreg_s;
    logic [BITS_PER_DIGIT-1:0] byte_s;
    logic [FW-1:0]            stage_r,    stage_s;
    logic [FW-1:0]            digits_r,   digits_s;
    logic                     valid_r,    valid_s;
    logic                     err_r,      err_s;
    logic                     ovf_r,      ovf_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset(reset), .d(sr_clk_in), .q(clk_lvl_s), .rise(clk_rise_s)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .reset(reset), .d(sr_latch_in), .q(latch_lvl_s), .rise(latch_rise_s)
    );

    // Only the aligned level of the data line is used; its edge output is unused.
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset(reset), .d(sr_data_in), .q(data_s), .rise(data_rise_s)
    );

    // Next-state logic: shift first, then the latch decision sees the post-shift counters.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        byte_cnt_s = byte_cnt_r;
        shreg_s    = shreg_r;
        stage_s    = stage_r;
        digits_s   = digits_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        ovf_s      = ovf_r;
        byte_s     = {shreg_r[BITS_PER_DIGIT-2:0], data_s};

        if (en) begin
            if ((state_r == RX_RECV) && clk_rise_s) begin
                shreg_s = byte_s;
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = '0;
                    if (byte_cnt_r == BYTE_FULL) begin
                        state_s = RX_OVERFLOW;
                        ovf_s   = 1'b1;
                    end else begin
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            if (byte_cnt_r == YCW'(k)) begin
                                stage_s[k*BITS_PER_DIGIT +: BITS_PER_DIGIT] = byte_s;
                            end else begin
                                stage_s[k*BITS_PER_DIGIT +: BITS_PER_DIGIT] =
                                    stage_r[k*BITS_PER_DIGIT +: BITS_PER_DIGIT];
                            end
                        end
                        byte_cnt_s = byte_cnt_r + BYTE_ONE;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end
            end else begin
                shreg_s = shreg_r;
            end

            if (latch_rise_s) begin
                case (state_r)
                    RX_IDLE: begin
                        state_s = RX_RECV;
                    end
                    RX_RECV: begin
                        // A byte overflowing on this very cycle also lands in the error path.
                        if ((state_s == RX_RECV) && (byte_cnt_s == BYTE_FULL) && (bit_cnt_s == '0)) begin
                            digits_s = stage_s;
                            valid_s  = 1'b1;
                            ovf_s    = 1'b0;
                        end else begin
                            err_s   = 1'b1;
                            state_s = RX_RECV;
                        end
                    end
                    RX_OVERFLOW: begin
                        err_s   = 1'b1;
                        state_s = RX_RECV;
                    end
                    default: begin
                        state_s = RX_IDLE;
                    end
                endcase
                bit_cnt_s  = '0;
                byte_cnt_s = '0;
            end else begin
                digits_s = digits_r;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counters, staging buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= RX_IDLE;
            bit_cnt_r  <= '0;
            byte_cnt_r <= '0;
            shreg_r    <= '0;
            stage_r    <= '0;
            digits_r   <= '0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            shreg_r    <= shreg_s;
            stage_r    <= stage_s;
            digits_r   <= digits_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            ovf_r      <= ovf_s;
        end
    end

    assign digits_out  = digits_r;
    assign frame_valid = valid_r;
    assign frame_err   = err_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_display_sr_receiver.sv
// Scoreboard bench for display_sr_receiver: a behavioural model pushes the
// expected frame result at each latch; a monitor pops it on every pulse.
module tb_display_sr_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        sr_clk_in = 1'b0;
    logic        sr_data_in = 1'b0;
    logic        sr_latch_in = 1'b0;
    logic [47:0] digits_out;
    logic        frame_valid;
    logic        frame_err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [47:0] dig;
    } exp_t;

    exp_t sb_q[$];

    // model state
    logic        m_idle = 1'b1;
    logic        m_ovst = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [47:0] m_dig  = 48'h0;
    logic        mbits[$];

    display_sr_receiver dut (
        .clk(clk), .reset(reset), .en(en),
        .sr_clk_in(sr_clk_in), .sr_data_in(sr_data_in), .sr_latch_in(sr_latch_in),
        .digits_out(digits_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_bit(input logic b);
        if (en && !m_idle && !m_ovst) begin
            mbits.push_back(b);
            if (mbits.size() == 56) begin
                m_ovst = 1'b1;
                m_ovf  = 1'b1;
            end
        end
    endtask

    task automatic model_latch();
        exp_t e;
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            if (!m_ovst && mbits.size() == 48) begin
                for (int k = 0; k < 6; k++)
                    for (int j = 0; j < 8; j++)
                        m_dig[k*8 + 7 - j] = mbits[k*8 + j];
                m_ovf   = 1'b0;
                e.valid = 1'b1;
            end else begin
                e.valid = 1'b0;
            end
            e.dig = m_dig;
            sb_q.push_back(e);
        end
        mbits.delete();
        m_ovst = 1'b0;
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_ovst = 1'b0;
        m_ovf  = 1'b0;
        m_dig  = 48'h0;
        mbits.delete();
    endtask

    task automatic send_bit(input logic b);
        sr_data_in = b;
        sr_clk_in  = 1'b0;
        cyc(4);
        model_bit(b);
        sr_clk_in = 1'b1;
        cyc(4);
        sr_clk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(b[7-i]);
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbytes);
        for (int k = 0; k < nbytes; k++) send_byte(f[k*8 +: 8], 8);
    endtask

    task automatic post_latch_checks(input string tag);
        cyc(6);
        chk({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    task automatic end_frame(input string tag);
        model_latch();
        sr_latch_in = 1'b1;
        cyc(4);
        sr_latch_in = 1'b0;
        post_latch_checks(tag);
    endtask

    // Last bit's shift-clock rise and latch rise driven together.
    task automatic bit_with_latch(input logic b, input string tag);
        sr_data_in = b;
        sr_clk_in  = 1'b0;
        cyc(4);
        model_bit(b);
        model_latch();
        sr_clk_in   = 1'b1;
        sr_latch_in = 1'b1;
        cyc(4);
        sr_clk_in   = 1'b0;
        sr_latch_in = 1'b0;
        post_latch_checks(tag);
    endtask

    // Monitor: every output pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (frame_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {62'd0, frame_valid, frame_err}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_valid", 64'(frame_valid), 64'(e.valid));
                chk("pulse_err", 64'(frame_err), 64'(!e.valid));
                chk("pulse_digits", 64'(digits_out), 64'(e.dig));
            end
        end
    end

    localparam logic [47:0] FRAME_A = {8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    localparam logic [47:0] FRAME_B = {8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39};
    localparam logic [47:0] FRAME_C = {8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30};

    initial begin
        // reset state
        cyc(3);
        chk("rst_digits", 64'(digits_out), 64'd0);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        cyc(3);

        // 1: first latch arms, then a good frame
        end_frame("t1_arm");
        send_frame(FRAME_A, 6);
        end_frame("t1_good");
        chk("t1_digits", 64'(digits_out), 64'(48'h6D664F5B063F));

        // 2: 47 bits -> error, then good frame
        send_frame(FRAME_B, 5);
        send_byte(FRAME_B[47:40], 7);
        end_frame("t2_short");
        chk("t2_hold", 64'(digits_out), 64'(48'h6D664F5B063F));
        send_frame(FRAME_B, 6);
        end_frame("t2_good");

        // 3: 56 bits -> overflow, error at latch, next good frame clears
        send_frame(FRAME_C, 6);
        send_byte(8'hA5, 8);
        cyc(6);
        chk("t3_ovf_set", 64'(overflow), 64'd1);
        end_frame("t3_ovf");
        send_frame(FRAME_A, 6);
        end_frame("t3_good");
        chk("t3_ovf_clr", 64'(overflow), 64'd0);

        // 4: bits before first latch after reset are never reported
        reset = 1'b1;
        model_reset();
        cyc(2);
        reset = 1'b0;
        cyc(2);
        send_byte(8'hC3, 8);
        send_byte(8'h5A, 2);
        end_frame("t4_idle");
        send_frame(FRAME_C, 5);
        send_byte(FRAME_C[47:40], 7);
        bit_with_latch(FRAME_C[40], "t4_simul");

        // 5: en low for 16 shift pulses mid-frame -> bits lost -> error
        send_frame(FRAME_B, 2);
        send_byte(FRAME_B[23:16], 4);
        en = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(i[0]);
        en = 1'b1;
        send_byte(FRAME_B[23:16], 8);
        send_byte(FRAME_B[31:24], 4);
        end_frame("t5_lost");
        // en toggled while the shift clock sits high: no extra bit
        send_frame(FRAME_A, 3);
        send_byte(FRAME_A[31:24], 7);
        sr_data_in = FRAME_A[24];
        cyc(4);
        model_bit(FRAME_A[24]);
        sr_clk_in = 1'b1;
        cyc(4);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(3);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(3);
        sr_clk_in = 1'b0;
        send_byte(FRAME_A[39:32], 8);
        send_byte(FRAME_A[47:40], 8);
        end_frame("t5_toggle");

        // 6: reset after 20 bits clears outputs immediately
        send_frame(FRAME_C, 2);
        send_byte(FRAME_C[23:16], 4);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_digits", 64'(digits_out), 64'd0);
        chk("t6_valid", 64'(frame_valid), 64'd0);
        chk("t6_err", 64'(frame_err), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        end_frame("t6_arm");
        send_frame(FRAME_C, 6);
        end_frame("t6_good");
        chk("t6_digits_new", 64'(digits_out), 64'(FRAME_C));

        cyc(10);
        chk("final_drain", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
